// File: rtl/ddr_cache_pkg.sv
// Shared definitions for the DDR row-cache subsystem: sync arbiter state encoding
// and bank-count / bank-index helpers used by the arbiter and the per-bank row cache.
package ddr_cache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWb,
        StFill,
        StSync,
        StDrain
    } arb_state_e;

    function automatic int unsigned nbanks(int unsigned bg_width, int unsigned ba_width);
        return 32'd1 << (bg_width + ba_width);
    endfunction

    // Bank index is {bg, ba}.
    function automatic int unsigned bank_index(int unsigned ba_width, int unsigned bg,
                                               int unsigned ba);
        return (bg << ba_width) | ba;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping to 0.
module rr_arbiter #(
    parameter int unsigned N = 16,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [IdxW-1:0] grant,
    output logic            valid
);

    logic [IdxW-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IdxW'((32'(ptr) + i) % N);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/cache_sync_arbiter.sv
// Serialises per-bank row-cache misses onto one backing-memory port: optional
// write-back of the victim row, fill of the missing row, then a sync pulse to the bank.
module cache_sync_arbiter
    import ddr_cache_pkg::*;
#(
    parameter int unsigned BGWIDTH   = 2,
    parameter int unsigned BAWIDTH   = 2,
    parameter int unsigned ADDRWIDTH = 17,
    parameter int unsigned BEATWIDTH = 3,
    localparam int unsigned NBANKS   = nbanks(BGWIDTH, BAWIDTH),
    localparam int unsigned BANKW    = BGWIDTH + BAWIDTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NBANKS-1:0]           miss_req,
    input  logic [NBANKS-1:0]           miss_dirty,
    input  logic [NBANKS*ADDRWIDTH-1:0] miss_row,
    input  logic [NBANKS*ADDRWIDTH-1:0] victim_row,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [BANKW-1:0]            mem_bank,
    output logic [ADDRWIDTH-1:0]        mem_row,
    output logic [BEATWIDTH-1:0]        mem_beat,
    input  logic                        mem_ack,
    output logic [NBANKS-1:0]           sync,
    output logic                        busy
);

    arb_state_e            state_q, state_d;
    logic [BANKW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [BANKW-1:0]      grant_q, grant_d;
    logic [BEATWIDTH-1:0]  beat_q, beat_d;
    logic [ADDRWIDTH-1:0]  wb_row_q, wb_row_d;
    logic [ADDRWIDTH-1:0]  fill_row_q, fill_row_d;

    logic [BANKW-1:0]      pick;
    logic                  pick_valid;
    logic                  beat_fire;
    logic                  beat_last;

    logic [ADDRWIDTH-1:0]  miss_row_arr   [NBANKS];
    logic [ADDRWIDTH-1:0]  victim_row_arr [NBANKS];

    for (genvar i = 0; i < NBANKS; i++) begin : g_rows
        assign miss_row_arr[i]   = miss_row[i*ADDRWIDTH +: ADDRWIDTH];
        assign victim_row_arr[i] = victim_row[i*ADDRWIDTH +: ADDRWIDTH];
    end

    rr_arbiter #(
        .N (NBANKS)
    ) u_rr_arbiter (
        .req   (miss_req),
        .ptr   (rr_ptr_q),
        .grant (pick),
        .valid (pick_valid)
    );

    assign beat_fire = mem_req && mem_ack;
    assign beat_last = &beat_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_d     = beat_q;
        wb_row_d   = wb_row_q;
        fill_row_d = fill_row_q;
        case (state_q)
            StIdle: begin
                // Everything the transaction needs is latched here so later
                // changes on the request inputs cannot disturb it.
                if (pick_valid) begin
                    grant_d    = pick;
                    wb_row_d   = victim_row_arr[pick];
                    fill_row_d = miss_row_arr[pick];
                    beat_d     = '0;
                    state_d    = miss_dirty[pick] ? StWb : StFill;
                end
            end
            StWb: begin
                if (beat_fire) begin
                    beat_d = beat_last ? '0 : beat_q + BEATWIDTH'(1);
                    if (beat_last) state_d = StFill;
                end
            end
            StFill: begin
                if (beat_fire) begin
                    beat_d = beat_last ? '0 : beat_q + BEATWIDTH'(1);
                    if (beat_last) state_d = StSync;
                end
            end
            StSync: begin
                rr_ptr_d = grant_q + BANKW'(1);
                state_d  = StDrain;
            end
            StDrain: begin
                // Wait for the bank to retire its miss so it is not serviced twice.
                if (!miss_req[grant_q]) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_q     <= '0;
            wb_row_q   <= '0;
            fill_row_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_q     <= beat_d;
            wb_row_q   <= wb_row_d;
            fill_row_q <= fill_row_d;
        end
    end

    assign mem_req  = (state_q == StWb) || (state_q == StFill);
    assign mem_we   = (state_q == StWb);
    assign mem_bank = grant_q;
    assign mem_beat = beat_q;
    assign busy     = (state_q != StIdle);

    always_comb begin
        mem_row = '0;
        if (state_q == StWb)   mem_row = wb_row_q;
        if (state_q == StFill) mem_row = fill_row_q;
    end

    always_comb begin
        sync = '0;
        if (state_q == StSync) sync[grant_q] = 1'b1;
    end

endmodule

// File: tb/tb_cache_sync_arbiter.sv
// Directed bench for cache_sync_arbiter: drives and samples on the falling edge.
module tb_cache_sync_arbiter;

    localparam int unsigned NB = 16;
    localparam int unsigned AW = 17;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NB-1:0]   miss_req;
    logic [NB-1:0]   miss_dirty;
    logic [NB*AW-1:0] miss_row;
    logic [NB*AW-1:0] victim_row;
    logic            mem_req;
    logic            mem_we;
    logic [3:0]      mem_bank;
    logic [AW-1:0]   mem_row;
    logic [2:0]      mem_beat;
    logic            mem_ack;
    logic [NB-1:0]   sync;
    logic            busy;

    int checks = 0;
    int errors = 0;

    cache_sync_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .miss_req   (miss_req),
        .miss_dirty (miss_dirty),
        .miss_row   (miss_row),
        .victim_row (victim_row),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_bank   (mem_bank),
        .mem_row    (mem_row),
        .mem_beat   (mem_beat),
        .mem_ack    (mem_ack),
        .sync       (sync),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] fill_of(input int b);
        return AW'(b * 32'h1111 + 5);
    endfunction

    function automatic logic [AW-1:0] wb_of(input int b);
        return AW'(32'h10000 | (b * 32'h123));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".req"},  32'(mem_req),  32'h0);
        check({tag, ".we"},   32'(mem_we),   32'h0);
        check({tag, ".bank"}, 32'(mem_bank), 32'h0);
        check({tag, ".row"},  32'(mem_row),  32'h0);
        check({tag, ".beat"}, 32'(mem_beat), 32'h0);
        check({tag, ".sync"}, 32'(sync),     32'h0);
        check({tag, ".busy"}, 32'(busy),     32'h0);
    endtask

    task automatic check_beat(input string tag, input bit we, input int bank,
                              input logic [AW-1:0] row, input int beat);
        check({tag, ".req"},  32'(mem_req),  32'h1);
        check({tag, ".we"},   32'(mem_we),   32'(we));
        check({tag, ".bank"}, 32'(mem_bank), 32'(bank));
        check({tag, ".row"},  32'(mem_row),  32'(row));
        check({tag, ".beat"}, 32'(mem_beat), 32'(beat));
        check({tag, ".sync"}, 32'(sync),     32'h0);
    endtask

    // Entered on the falling edge where beat 'first' must be visible.
    task automatic run_beats(input string tag, input bit we, input int bank,
                             input logic [AW-1:0] row, input int first, input int last,
                             input bit toggle);
        for (int b = first; b <= last; b++) begin
            check_beat(tag, we, bank, row, b);
            if (toggle) begin
                mem_ack = 1'b0;
                @(negedge clk);
                check_beat({tag, ".hold"}, we, bank, row, b);
            end
            mem_ack = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic check_sync(input string tag, input int bank);
        check({tag, ".sync"}, 32'(sync),    32'h1 << bank);
        check({tag, ".req"},  32'(mem_req), 32'h0);
        check({tag, ".busy"}, 32'(busy),    32'h1);
    endtask

    task automatic check_drain(input string tag);
        check({tag, ".sync"}, 32'(sync),    32'h0);
        check({tag, ".req"},  32'(mem_req), 32'h0);
        check({tag, ".busy"}, 32'(busy),    32'h1);
    endtask

    initial begin
        reset_n    = 1'b0;
        miss_req   = '0;
        miss_dirty = '0;
        mem_ack    = 1'b0;
        for (int b = 0; b < NB; b++) begin
            miss_row[b*AW +: AW]   = fill_of(b);
            victim_row[b*AW +: AW] = wb_of(b);
        end
        #1;
        check_idle_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Clean miss on bank 5; ack held high in idle must be ignored.
        mem_ack  = 1'b1;
        miss_req = 16'h0020;
        check("clean.idle_req", 32'(mem_req), 32'h0);
        check("clean.idle_busy", 32'(busy), 32'h0);
        @(negedge clk);
        run_beats("clean", 1'b0, 5, fill_of(5), 0, 7, 1'b0);
        check_sync("clean", 5);
        @(negedge clk);
        check_drain("clean.drain0");
        @(negedge clk);
        check_drain("clean.drain1");
        miss_req = '0;
        @(negedge clk);
        check("clean.done_busy", 32'(busy), 32'h0);

        // Dirty miss on bank 3: write-back then fill.
        miss_row[3*AW +: AW]   = 17'h00042;
        victim_row[3*AW +: AW] = 17'h1ABCD;
        miss_dirty = 16'h0008;
        miss_req   = 16'h0008;
        @(negedge clk);
        run_beats("dirty.wb", 1'b1, 3, 17'h1ABCD, 0, 7, 1'b0);
        run_beats("dirty.fill", 1'b0, 3, 17'h00042, 0, 7, 1'b0);
        check_sync("dirty", 3);
        miss_req   = '0;
        miss_dirty = '0;
        @(negedge clk);
        check_drain("dirty.drain");
        @(negedge clk);
        check("dirty.done_busy", 32'(busy), 32'h0);

        // Backpressure: every other cycle unacked, beat must hold.
        miss_req = 16'h0040;
        @(negedge clk);
        run_beats("bp", 1'b0, 6, fill_of(6), 0, 7, 1'b1);
        check_sync("bp", 6);
        miss_req = '0;
        @(negedge clk);
        @(negedge clk);
        check("bp.done_busy", 32'(busy), 32'h0);

        // Request withdrawn mid-transfer: transfer still completes.
        miss_req = 16'h0004;
        @(negedge clk);
        run_beats("drop", 1'b0, 2, fill_of(2), 0, 2, 1'b0);
        miss_req = '0;
        run_beats("drop", 1'b0, 2, fill_of(2), 3, 7, 1'b0);
        check_sync("drop", 2);
        @(negedge clk);
        check_drain("drop.drain");
        @(negedge clk);
        check("drop.done_busy", 32'(busy), 32'h0);

        // Fairness: serve bank 14 so rr_ptr is 15, then 0x8001 alternates 15,0,15,0.
        miss_req = 16'h4000;
        @(negedge clk);
        run_beats("rr.pre", 1'b0, 14, fill_of(14), 0, 7, 1'b0);
        check_sync("rr.pre", 14);
        miss_req = '0;
        @(negedge clk);
        @(negedge clk);
        miss_req = 16'h8001;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            int g;
            g = (k % 2 == 0) ? 15 : 0;
            run_beats("rr", 1'b0, g, fill_of(g), 0, 7, 1'b0);
            check_sync("rr", g);
            miss_req[g] = 1'b0;
            @(negedge clk);
            check_drain("rr.drain");
            @(negedge clk);
            check("rr.idle_busy", 32'(busy), 32'h0);
            miss_req = (k < 3) ? 16'h8001 : 16'h0000;
            @(negedge clk);
        end

        // Reset at fill beat 4: outputs clear at once, no sync, restart at beat 0.
        miss_req = 16'h0020;
        @(negedge clk);
        run_beats("rst", 1'b0, 5, fill_of(5), 0, 3, 1'b0);
        check_beat("rst.beat4", 1'b0, 5, fill_of(5), 4);
        reset_n = 1'b0;
        #1;
        check_idle_zero("rst.async");
        @(negedge clk);
        check_idle_zero("rst.held");
        reset_n = 1'b1;
        @(negedge clk);
        run_beats("rst.restart", 1'b0, 5, fill_of(5), 0, 7, 1'b0);
        check_sync("rst.restart", 5);
        miss_req = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst.done_busy", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
